// File: rtl/tick_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tick_sched
//  Description : Multi-channel timebase scheduler. A shared prescaler turns
//                clk_50MHz into a base tick. Each channel divides that tick
//                into tick pulses and a square wave. Channels are controlled
//                through one valid/ready command port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_sched #(
    parameter  int N_CH       = 4,
    parameter  int PRESC      = 50000,
    parameter  int PW         = 16,
    parameter  int DEF_PERIOD = 500,
    localparam int CHW        = $clog2(N_CH)
) (
    input  logic            clk_50MHz,
    input  logic            reset_button,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [1:0]      cfg_cmd,
    input  logic [PW-1:0]   cfg_period,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq_out,
    output logic [N_CH-1:0] active
);

    localparam int              c_presc_w    = $clog2(PRESC);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESC - 1);

    localparam logic [1:0] c_cmd_stop    = 2'd0;
    localparam logic [1:0] c_cmd_run     = 2'd1;
    localparam logic [1:0] c_cmd_oneshot = 2'd2;
    localparam logic [1:0] c_cmd_load    = 2'd3;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ONESHOT = 2'd2
    } ch_state_t;

    logic [c_presc_w-1:0] r_presc;
    logic                 w_base_tk;
    logic                 r_cfg_ready;
    logic                 w_accept;

    assign w_base_tk = (r_presc == c_presc_last);
    assign w_accept  = cfg_valid && r_cfg_ready;
    assign cfg_ready = r_cfg_ready;

    // Free-running prescaler shared by every channel; commands never touch it.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_presc <= '0;
        end else if (w_base_tk) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Ready rises after reset and drops for one cycle after every accept.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_cfg_ready <= 1'b0;
        end else begin
            r_cfg_ready <= ~w_accept;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            localparam logic [CHW-1:0] c_ch_idx = CHW'(i);

            ch_state_t     r_state, w_state_nxt;
            logic [PW-1:0] r_cnt, w_cnt_nxt;
            logic [PW-1:0] r_period, w_period_nxt;
            logic [PW-1:0] r_pend, w_pend_nxt;
            logic          r_pend_vld, w_pend_vld_nxt;
            logic          r_tick, w_tick_nxt;
            logic          r_sq, w_sq_nxt;
            logic [PW-1:0] w_eff;
            logic          w_hit;

            // A programmed half-period of 0 behaves as 1.
            assign w_eff = (r_period == '0) ? PW'(1) : r_period;
            // Out-of-range channel numbers never match, so they are ignored.
            assign w_hit = w_accept && (cfg_ch == c_ch_idx);

            // Channel state register; reset clears everything immediately.
            always_ff @(posedge clk_50MHz or posedge reset_button) begin
                if (reset_button) begin
                    r_state    <= ST_STOP;
                    r_cnt      <= '0;
                    r_period   <= PW'(DEF_PERIOD);
                    r_pend     <= '0;
                    r_pend_vld <= 1'b0;
                    r_tick     <= 1'b0;
                    r_sq       <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_cnt      <= w_cnt_nxt;
                    r_period   <= w_period_nxt;
                    r_pend     <= w_pend_nxt;
                    r_pend_vld <= w_pend_vld_nxt;
                    r_tick     <= w_tick_nxt;
                    r_sq       <= w_sq_nxt;
                end
            end

            // Counting and wrap first, then any command layered on top.
            always_comb begin
                w_state_nxt    = r_state;
                w_cnt_nxt      = r_cnt;
                w_period_nxt   = r_period;
                w_pend_nxt     = r_pend;
                w_pend_vld_nxt = r_pend_vld;
                w_tick_nxt     = 1'b0;
                w_sq_nxt       = r_sq;

                if ((r_state != ST_STOP) && w_base_tk) begin
                    if (r_cnt == (w_eff - 1'b1)) begin
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                        w_sq_nxt   = ~r_sq;
                        if (r_pend_vld) begin
                            w_period_nxt   = r_pend;
                            w_pend_vld_nxt = 1'b0;
                        end
                        if (r_state == ST_ONESHOT) begin
                            w_state_nxt = ST_STOP;
                            w_sq_nxt    = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                if (w_hit) begin
                    case (cfg_cmd)
                        c_cmd_stop: begin
                            w_state_nxt    = ST_STOP;
                            w_cnt_nxt      = '0;
                            w_sq_nxt       = 1'b0;
                            w_pend_vld_nxt = 1'b0;
                        end
                        c_cmd_run: begin
                            if (w_state_nxt == ST_STOP) begin
                                w_cnt_nxt = '0;
                                w_sq_nxt  = 1'b0;
                            end
                            w_state_nxt = ST_RUN;
                        end
                        c_cmd_oneshot: begin
                            if (w_state_nxt == ST_STOP) begin
                                w_cnt_nxt = '0;
                                w_sq_nxt  = 1'b0;
                            end
                            w_state_nxt = ST_ONESHOT;
                        end
                        c_cmd_load: begin
                            if (w_state_nxt == ST_STOP) begin
                                w_period_nxt = cfg_period;
                            end else begin
                                w_pend_nxt     = cfg_period;
                                w_pend_vld_nxt = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = w_state_nxt;
                        end
                    endcase
                end
            end

            assign tick[i]   = r_tick;
            assign sq_out[i] = r_sq;
            assign active[i] = (r_state != ST_STOP);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tick_sched
//  Description : Self-checking bench for tick_sched. Expected tick cycles are
//                pushed to per-channel queues when commands are issued and
//                popped by a monitor when ticks appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sched;

    localparam int N_CH  = 4;
    localparam int PRESC = 4;
    localparam int PW    = 8;

    localparam logic [1:0] c_stop    = 2'd0;
    localparam logic [1:0] c_run     = 2'd1;
    localparam logic [1:0] c_oneshot = 2'd2;
    localparam logic [1:0] c_load    = 2'd3;

    logic            clk_50MHz    = 1'b0;
    logic            reset_button = 1'b1;
    logic            cfg_valid    = 1'b0;
    logic            cfg_valid3   = 1'b0;
    logic [1:0]      cfg_ch       = '0;
    logic [1:0]      cfg_cmd      = '0;
    logic [PW-1:0]   cfg_period   = '0;
    logic            cfg_ready, cfg_ready3;
    logic [N_CH-1:0] tick, sq_out, active;
    logic [2:0]      tick3, sq_out3, active3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q [N_CH][$];

    always #5 clk_50MHz = ~clk_50MHz;

    tick_sched #(.N_CH(N_CH), .PRESC(PRESC), .PW(PW), .DEF_PERIOD(3)) dut (
        .clk_50MHz(clk_50MHz), .reset_button(reset_button),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_cmd(cfg_cmd), .cfg_period(cfg_period),
        .tick(tick), .sq_out(sq_out), .active(active)
    );

    tick_sched #(.N_CH(3), .PRESC(PRESC), .PW(PW), .DEF_PERIOD(3)) dut3 (
        .clk_50MHz(clk_50MHz), .reset_button(reset_button),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch),
        .cfg_cmd(cfg_cmd), .cfg_period(cfg_period),
        .tick(tick3), .sq_out(sq_out3), .active(active3)
    );

    // Edge count since reset release: edge n leaves cyc == n.
    always @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) cyc <= 0;
        else              cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int base_of(input int a);
        return (a / PRESC) * PRESC;
    endfunction

    // Scoreboard monitor: every tick must match the oldest expected cycle.
    always @(negedge clk_50MHz) begin
        int e;
        if (!reset_button) begin
            for (int c = 0; c < N_CH; c++) begin
                if (tick[c]) begin
                    if (exp_q[c].size() == 0) begin
                        flag($sformatf("unexpected_tick_ch%0d", c), cyc, -1);
                    end else begin
                        e = exp_q[c].pop_front();
                        check($sformatf("tick_time_ch%0d", c), cyc, e);
                    end
                end else if (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
                    e = exp_q[c].pop_front();
                    flag($sformatf("missed_tick_ch%0d", c), -1, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n) begin
            @(negedge clk_50MHz);
            g++;
            if (g > 4000) begin
                flag("wait_timeout", cyc, n);
                return;
            end
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [1:0] cmd,
                        input logic [PW-1:0] per, output int acc);
        int g = 0;
        @(negedge clk_50MHz);
        cfg_ch = ch; cfg_cmd = cmd; cfg_period = per; cfg_valid = 1'b1;
        while (!cfg_ready) begin
            @(negedge clk_50MHz);
            g++;
            if (g > 50) begin
                flag("ready_timeout", 0, 1);
                break;
            end
        end
        acc = cyc + 1;
        @(negedge clk_50MHz);
        cfg_valid = 1'b0;
    endtask

    task automatic send_at(input int target, input logic [1:0] ch, input logic [1:0] cmd);
        wait_cyc(target - 1);
        cfg_ch = ch; cfg_cmd = cmd; cfg_period = '0; cfg_valid = 1'b1;
        check("ready_before_timed_cmd", cfg_ready, 1);
        @(negedge clk_50MHz);
        cfg_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic [1:0] cmd);
        int g = 0;
        @(negedge clk_50MHz);
        cfg_ch = ch; cfg_cmd = cmd; cfg_period = '0; cfg_valid3 = 1'b1;
        while (!cfg_ready3) begin
            @(negedge clk_50MHz);
            g++;
            if (g > 50) begin
                flag("ready3_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk_50MHz);
        cfg_valid3 = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    ch;
        bit            load;
        logic [PW-1:0] per;
        int            sp;
    } vec_t;

    typedef struct {
        logic [1:0]    ch;
        logic [1:0]    cmd;
        logic [PW-1:0] per;
    } qcmd_t;

    initial begin
        vec_t  tbl [5];
        qcmd_t qc [3];
        int    acc [3];
        int    a, a2, t1, t2, idx, sp;
        logic [1:0] ch;
        logic  seen;
        bit    exp_pat [5];

        tbl[0] = '{ch: 2'd0, load: 1'b0, per: 8'd0, sp: 12};
        tbl[1] = '{ch: 2'd1, load: 1'b1, per: 8'd1, sp: 4};
        tbl[2] = '{ch: 2'd2, load: 1'b1, per: 8'd0, sp: 4};
        tbl[3] = '{ch: 2'd3, load: 1'b1, per: 8'd6, sp: 24};
        tbl[4] = '{ch: 2'd0, load: 1'b1, per: 8'd2, sp: 8};
        qc[0]  = '{ch: 2'd3, cmd: c_load, per: 8'd2};
        qc[1]  = '{ch: 2'd3, cmd: c_run,  per: 8'd0};
        qc[2]  = '{ch: 2'd3, cmd: c_load, per: 8'd1};
        exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_tick", tick, 0);
        check("rst_sq", sq_out, 0);
        check("rst_active", active, 0);
        check("rst_ready", cfg_ready, 0);
        #11 reset_button = 1'b0;
        #1  check("ready_before_first_edge", cfg_ready, 0);
        @(negedge clk_50MHz);
        check("ready_after_first_edge", cfg_ready, 1);

        // Table: program, run for three ticks, check square wave, stop
        for (int i = 0; i < 5; i++) begin
            ch = tbl[i].ch;
            sp = tbl[i].sp;
            if (tbl[i].load) send(ch, c_load, tbl[i].per, a);
            send(ch, c_run, '0, a);
            t1 = base_of(a) + sp;
            exp_q[ch].push_back(t1);
            exp_q[ch].push_back(t1 + sp);
            exp_q[ch].push_back(t1 + 2 * sp);
            check($sformatf("tbl%0d_active", i), active[ch], 1);
            check($sformatf("tbl%0d_sq_start", i), sq_out[ch], 0);
            wait_cyc(t1);
            check($sformatf("tbl%0d_sq_tick1", i), sq_out[ch], 1);
            wait_cyc(t1 + sp);
            check($sformatf("tbl%0d_sq_tick2", i), sq_out[ch], 0);
            wait_cyc(t1 + 2 * sp);
            check($sformatf("tbl%0d_sq_tick3", i), sq_out[ch], 1);
            send(ch, c_stop, '0, a);
            check($sformatf("tbl%0d_stop_active", i), active[ch], 0);
            check($sformatf("tbl%0d_stop_sq", i), sq_out[ch], 0);
        end

        // ONESHOT with a LOAD during the interval
        send(2'd2, c_load, 8'd3, a);
        send(2'd2, c_oneshot, '0, a);
        t1 = base_of(a) + 12;
        exp_q[2].push_back(t1);
        send(2'd2, c_load, 8'd5, a2);
        wait_cyc(t1 - 1);
        check("oneshot_active_before", active[2], 1);
        wait_cyc(t1);
        check("oneshot_active_after", active[2], 0);
        check("oneshot_sq_after", sq_out[2], 0);
        wait_cyc(t1 + 40);
        send(2'd2, c_run, '0, a);
        t1 = base_of(a) + 20;
        exp_q[2].push_back(t1);
        exp_q[2].push_back(t1 + 20);
        wait_cyc(t1 + 20);
        send(2'd2, c_stop, '0, a);

        // LOAD while running takes effect after the next wrap
        send(2'd1, c_load, 8'd3, a);
        send(2'd1, c_run, '0, a);
        t1 = base_of(a) + 12;
        exp_q[1].push_back(t1);
        wait_cyc(t1);
        send(2'd1, c_load, 8'd1, a2);
        t2 = t1 + 12;
        exp_q[1].push_back(t2);
        exp_q[1].push_back(t2 + 4);
        exp_q[1].push_back(t2 + 8);
        wait_cyc(t2 + 8);
        send(2'd1, c_stop, '0, a);

        // Three queued commands with cfg_valid held high
        @(negedge clk_50MHz);
        idx = 0;
        cfg_ch = qc[0].ch; cfg_cmd = qc[0].cmd; cfg_period = qc[0].per;
        cfg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ready_pattern_%0d", k), cfg_ready, exp_pat[k]);
            if (cfg_ready && idx < 3) begin
                acc[idx] = cyc + 1;
                idx++;
            end
            @(negedge clk_50MHz);
            if (idx < 3) begin
                cfg_ch = qc[idx].ch; cfg_cmd = qc[idx].cmd; cfg_period = qc[idx].per;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        cfg_valid = 1'b0;
        check("queued_accepts", idx, 3);
        if (idx == 3) begin
            t1 = base_of(acc[1]) + 8;
            exp_q[3].push_back(t1);
            exp_q[3].push_back(t1 + 4);
            exp_q[3].push_back(t1 + 8);
            wait_cyc(t1 + 8);
        end
        send(2'd3, c_stop, '0, a);

        // Out-of-range channel on a 3-channel instance is accepted and ignored
        send3(2'd3, c_run);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_50MHz);
            seen = seen | (|tick3) | (|active3) | (|sq_out3);
        end
        check("out_of_range_ignored", seen, 0);
        send3(2'd2, c_run);
        check("in_range_dut3_active", active3, 3'b100);

        // STOP landing on the exact wrap edge of ch0 (period 2)
        send(2'd0, c_load, 8'd2, a);
        send(2'd0, c_run, '0, a);
        t1 = base_of(a) + 8;
        exp_q[0].push_back(t1);
        send_at(t1, 2'd0, c_stop);
        check("stop_at_wrap_sq", sq_out[0], 0);
        check("stop_at_wrap_active", active[0], 0);
        wait_cyc(t1 + 30);

        // Asynchronous reset in the middle of a run
        send(2'd0, c_run, '0, a);
        t1 = base_of(a) + 8;
        exp_q[0].push_back(t1);
        wait_cyc(t1 + 1);
        check("pre_reset_sq", sq_out[0], 1);
        #2 reset_button = 1'b1;
        for (int c = 0; c < N_CH; c++) exp_q[c].delete();
        #1;
        check("async_rst_sq", sq_out, 0);
        check("async_rst_active", active, 0);
        check("async_rst_ready", cfg_ready, 0);
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        #2 reset_button = 1'b0;
        @(negedge clk_50MHz);
        wait_cyc(20);
        check("post_reset_stopped", active[0], 0);
        send(2'd0, c_run, '0, a);
        t1 = base_of(a) + 12;
        exp_q[0].push_back(t1);
        exp_q[0].push_back(t1 + 12);
        wait_cyc(t1 + 12);
        send(2'd0, c_stop, '0, a);

        wait_cyc(cyc + 10);
        for (int c = 0; c < N_CH; c++)
            check($sformatf("queue_drained_ch%0d", c), exp_q[c].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
